// File: rtl/credit_accumulator.sv
// Coin credit accumulator: keeps a running credit, deducts vend prices and refunds change on cancel.
// Optional AUTO_REFUND_EN adds an idle timer that forces a refund after TIMEOUT_CYCLES quiet HOLD cycles.
module credit_accumulator #(
   parameter int unsigned CREDIT_MAX   = 200,
   parameter int unsigned PRICE_APPLE  = 75,
   parameter int unsigned PRICE_BANANA = 20,
   parameter int unsigned PRICE_CARROT = 30,
   parameter int unsigned PRICE_DATE   = 40
`ifdef AUTO_REFUND_EN
   , parameter int unsigned TIMEOUT_CYCLES = 1000
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       coin_valid,
   input  logic [1:0] coin_type,
   input  logic       cancel,
   input  logic       vend_apple,
   input  logic       vend_banana,
   input  logic       vend_carrot,
   input  logic       vend_date,
   output logic [7:0] credit,
   output logic       coin_reject,
   output logic       quarter_out,
   output logic       dime_out,
   output logic       nickel_out,
   output logic       refund_busy
);

   typedef enum logic [1:0] {IDLE, HOLD, REFUND} state_t;

   localparam logic [8:0] CREDIT_CEIL = 9'(CREDIT_MAX);

   state_t     state_q, state_d;
   logic [7:0] credit_q, credit_d;
   logic       coin_reject_q, coin_reject_d;
   logic       quarter_q, quarter_d;
   logic       dime_q, dime_d;
   logic       nickel_q, nickel_d;
   logic       busy_q, busy_d;

   logic [8:0] coin_value;
   logic [7:0] price;
   logic       vend_any;
   logic [7:0] base_credit;
   logic [8:0] sum;
   logic       timeout;

   always_comb begin
      case (coin_type)
         2'd0:    coin_value = 9'd5;
         2'd1:    coin_value = 9'd10;
         2'd2:    coin_value = 9'd25;
         default: coin_value = 9'd100;
      endcase
   end

   // Simultaneous vends resolve apple > banana > carrot > date.
   always_comb begin
      price    = 8'd0;
      vend_any = vend_apple | vend_banana | vend_carrot | vend_date;
      if (vend_apple)       price = 8'(PRICE_APPLE);
      else if (vend_banana) price = 8'(PRICE_BANANA);
      else if (vend_carrot) price = 8'(PRICE_CARROT);
      else if (vend_date)   price = 8'(PRICE_DATE);
   end

   assign base_credit = (price > credit_q) ? 8'd0 : credit_q - price;
   assign sum         = {1'b0, base_credit} + coin_value;

`ifdef AUTO_REFUND_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] timer_q, timer_d;
   logic        activity;

   always_comb begin
      activity = coin_valid | vend_any | cancel;
      timeout  = (state_q == HOLD) && !activity && (timer_q == TIMEOUT_LAST);
      timer_d  = timer_q + 16'd1;
      if (state_q != HOLD || activity || timeout) timer_d = 16'd0;
   end

   always_ff @(posedge clk) begin
      if (!reset) timer_q <= 16'd0;
      else        timer_q <= timer_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d       = state_q;
      credit_d      = credit_q;
      coin_reject_d = 1'b0;
      quarter_d     = 1'b0;
      dime_d        = 1'b0;
      nickel_d      = 1'b0;
      case (state_q)
         IDLE, HOLD: begin
            if (state_q == HOLD && (cancel || timeout)) begin
               credit_d      = base_credit;
               coin_reject_d = coin_valid;
               state_d       = REFUND;
            end else begin
               credit_d = base_credit;
               if (coin_valid) begin
                  if (sum <= CREDIT_CEIL) credit_d = sum[7:0];
                  else                    coin_reject_d = 1'b1;
               end
               state_d = (credit_d != 8'd0) ? HOLD : IDLE;
            end
         end
         REFUND: begin
            // Largest coin first; a sub-nickel remainder is forfeited.
            coin_reject_d = coin_valid;
            if (credit_q >= 8'd25) begin
               quarter_d = 1'b1;
               credit_d  = credit_q - 8'd25;
            end else if (credit_q >= 8'd10) begin
               dime_d   = 1'b1;
               credit_d = credit_q - 8'd10;
            end else if (credit_q >= 8'd5) begin
               nickel_d = 1'b1;
               credit_d = credit_q - 8'd5;
            end else begin
               credit_d = 8'd0;
            end
            if (credit_d == 8'd0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == REFUND);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!reset) begin
         state_q       <= IDLE;
         credit_q      <= 8'd0;
         coin_reject_q <= 1'b0;
         quarter_q     <= 1'b0;
         dime_q        <= 1'b0;
         nickel_q      <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         coin_reject_q <= coin_reject_d;
         quarter_q     <= quarter_d;
         dime_q        <= dime_d;
         nickel_q      <= nickel_d;
         busy_q        <= busy_d;
      end
   end

   assign credit      = credit_q;
   assign coin_reject = coin_reject_q;
   assign quarter_out = quarter_q;
   assign dime_out    = dime_q;
   assign nickel_out  = nickel_q;
   assign refund_busy = busy_q;

endmodule

// File: tb/tb_credit_accumulator.sv
// Bench for credit_accumulator: directed vector table, a refund-length sequence, and random
// stimulus checked against a change-queue model of the credit rules.
module tb_credit_accumulator;

   logic       clk = 1'b0;
   logic       reset;
   logic       coin_valid;
   logic [1:0] coin_type;
   logic       cancel;
   logic       vend_apple, vend_banana, vend_carrot, vend_date;
   logic [7:0] credit;
   logic       coin_reject, quarter_out, dime_out, nickel_out, refund_busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   credit_accumulator dut (
      .clk         (clk),
      .reset       (reset),
      .coin_valid  (coin_valid),
      .coin_type   (coin_type),
      .cancel      (cancel),
      .vend_apple  (vend_apple),
      .vend_banana (vend_banana),
      .vend_carrot (vend_carrot),
      .vend_date   (vend_date),
      .credit      (credit),
      .coin_reject (coin_reject),
      .quarter_out (quarter_out),
      .dime_out    (dime_out),
      .nickel_out  (nickel_out),
      .refund_busy (refund_busy)
   );

   typedef struct {
      bit       rst;
      bit       cv;
      bit [1:0] ct;
      bit       cn;
      bit [3:0] vd;   // {apple, banana, carrot, date}
      int       cr;
      bit       rj, q, d, n, b;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive at the falling edge, sample 1 ns after the rising edge.
   task automatic apply(input bit r, input bit cv, input bit [1:0] ct, input bit cn, input bit [3:0] vd);
      @(negedge clk);
      reset       = r;
      coin_valid  = cv;
      coin_type   = ct;
      cancel      = cn;
      {vend_apple, vend_banana, vend_carrot, vend_date} = vd;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input int cr, input bit rj, q, d, n, b);
      check({tag, " credit"},      32'(credit),      32'(cr));
      check({tag, " coin_reject"}, 32'(coin_reject), 32'(rj));
      check({tag, " quarter_out"}, 32'(quarter_out), 32'(q));
      check({tag, " dime_out"},    32'(dime_out),    32'(d));
      check({tag, " nickel_out"},  32'(nickel_out),  32'(n));
      check({tag, " refund_busy"}, 32'(refund_busy), 32'(b));
   endtask

   function automatic vec_t mk(input bit r, cv, input bit [1:0] ct, input bit cn, input bit [3:0] vd,
                               input int cr, input bit rj, q, d, n, b);
      vec_t v;
      v.rst = r; v.cv = cv; v.ct = ct; v.cn = cn; v.vd = vd;
      v.cr = cr; v.rj = rj; v.q = q; v.d = d; v.n = n; v.b = b;
      return v;
   endfunction

   // Reference model: credit as an integer, refund as a precomputed greedy change list.
   int  m_credit;
   bit  m_refunding;
   bit  m_rj, m_q, m_d, m_n;
   int  change[$];

   task automatic model_step(input bit r, cv, input bit [1:0] ct, input bit cn, input bit [3:0] vd);
      int price, val, c, rem;
      bit was_hold;
      m_rj = 0; m_q = 0; m_d = 0; m_n = 0;
      if (!r) begin
         m_credit = 0;
         m_refunding = 0;
         change.delete();
      end else if (m_refunding) begin
         m_rj = cv;
         if (change.size() > 0) begin
            c = change.pop_front();
            m_credit -= c;
            m_q = (c == 25); m_d = (c == 10); m_n = (c == 5);
         end else begin
            m_credit = 0;
         end
         if (m_credit == 0) m_refunding = 0;
      end else begin
         was_hold = (m_credit > 0);
         price = vd[3] ? 75 : vd[2] ? 20 : vd[1] ? 30 : vd[0] ? 40 : 0;
         m_credit = (price > m_credit) ? 0 : m_credit - price;
         if (cn && was_hold) begin
            m_rj = cv;
            m_refunding = 1;
            rem = m_credit;
            while (rem >= 25) begin change.push_back(25); rem -= 25; end
            while (rem >= 10) begin change.push_back(10); rem -= 10; end
            while (rem >= 5)  begin change.push_back(5);  rem -= 5;  end
         end else if (cv) begin
            val = (ct == 0) ? 5 : (ct == 1) ? 10 : (ct == 2) ? 25 : 100;
            if (m_credit + val <= 200) m_credit += val;
            else m_rj = 1;
         end
      end
   endtask

   initial begin
      int busy_cycles;
      int pulses[$];
      int seq[3];

      // r cv ct cn vd        credit rj q d n b
      vecs.push_back(mk(0,0,0,0,4'b0000,   0, 0,0,0,0,0));
      vecs.push_back(mk(1,1,2,0,4'b0000,  25, 0,0,0,0,0));
      vecs.push_back(mk(1,1,2,0,4'b0000,  50, 0,0,0,0,0));
      vecs.push_back(mk(1,1,2,0,4'b0000,  75, 0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,4'b1000,   0, 0,0,0,0,0));
      vecs.push_back(mk(1,1,3,0,4'b0000, 100, 0,0,0,0,0));
      vecs.push_back(mk(1,1,2,0,4'b0000, 125, 0,0,0,0,0));
      vecs.push_back(mk(1,1,2,0,4'b0000, 150, 0,0,0,0,0));
      vecs.push_back(mk(1,1,3,0,4'b0000, 150, 1,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,4'b0000, 150, 0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,4'b1000,  75, 0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,4'b1000,   0, 0,0,0,0,0));
      vecs.push_back(mk(1,1,2,0,4'b0000,  25, 0,0,0,0,0));
      vecs.push_back(mk(1,1,1,0,4'b0000,  35, 0,0,0,0,0));
      vecs.push_back(mk(1,1,1,0,4'b0000,  45, 0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,4'b0000,  45, 0,0,0,0,1));
      vecs.push_back(mk(1,1,0,0,4'b0000,  20, 1,1,0,0,1));
      vecs.push_back(mk(1,0,0,1,4'b1000,  10, 0,0,1,0,1));
      vecs.push_back(mk(1,0,0,0,4'b0000,   0, 0,0,1,0,0));
      vecs.push_back(mk(1,1,1,0,4'b0000,  10, 0,0,0,0,0));
      vecs.push_back(mk(1,1,1,0,4'b0000,  20, 0,0,0,0,0));
      vecs.push_back(mk(1,1,0,0,4'b0100,   5, 0,0,0,0,0));
      vecs.push_back(mk(1,1,1,0,4'b0000,  15, 0,0,0,0,0));
      vecs.push_back(mk(1,1,0,0,4'b0000,  20, 0,0,0,0,0));
      vecs.push_back(mk(1,1,0,0,4'b0000,  25, 0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,4'b0100,   5, 0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,4'b0001,   0, 0,0,0,0,0));
      vecs.push_back(mk(1,1,3,0,4'b0000, 100, 0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,4'b0110,  80, 0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,4'b0011,  50, 0,0,0,0,0));
      vecs.push_back(mk(1,1,3,0,4'b0000, 150, 0,0,0,0,0));
      vecs.push_back(mk(1,1,2,0,4'b0000, 175, 0,0,0,0,0));
      vecs.push_back(mk(1,1,2,0,4'b0000, 200, 0,0,0,0,0));
      vecs.push_back(mk(1,1,0,0,4'b0000, 200, 1,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,4'b1000, 125, 0,0,0,0,1));
      vecs.push_back(mk(1,0,0,0,4'b0000, 100, 0,1,0,0,1));
      vecs.push_back(mk(1,0,0,0,4'b0000,  75, 0,1,0,0,1));
      vecs.push_back(mk(1,0,0,0,4'b0000,  50, 0,1,0,0,1));
      vecs.push_back(mk(1,0,0,0,4'b0000,  25, 0,1,0,0,1));
      vecs.push_back(mk(1,0,0,0,4'b0000,   0, 0,1,0,0,0));
      vecs.push_back(mk(1,0,0,1,4'b0000,   0, 0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,4'b0010,   0, 0,0,0,0,0));
      vecs.push_back(mk(1,1,1,0,4'b0000,  10, 0,0,0,0,0));
      vecs.push_back(mk(1,1,2,1,4'b0000,  10, 1,0,0,0,1));
      vecs.push_back(mk(1,0,0,0,4'b0000,   0, 0,0,1,0,0));
      vecs.push_back(mk(1,1,3,0,4'b0000, 100, 0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,4'b0000, 100, 0,0,0,0,1));
      vecs.push_back(mk(1,0,0,0,4'b0000,  75, 0,1,0,0,1));
      vecs.push_back(mk(0,0,0,0,4'b0000,   0, 0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,4'b0000,   0, 0,0,0,0,0));

      reset = 1'b0; coin_valid = 1'b0; coin_type = 2'd0; cancel = 1'b0;
      vend_apple = 1'b0; vend_banana = 1'b0; vend_carrot = 1'b0; vend_date = 1'b0;

      foreach (vecs[i]) begin
         apply(vecs[i].rst, vecs[i].cv, vecs[i].ct, vecs[i].cn, vecs[i].vd);
         check_all($sformatf("vec%0d", i), vecs[i].cr, vecs[i].rj, vecs[i].q, vecs[i].d,
                   vecs[i].n, vecs[i].b);
      end

      // Refund of 45: quarter, dime, dime on consecutive cycles, busy for exactly 3 cycles.
      apply(0, 0, 0, 0, 4'b0000);
      apply(1, 1, 2, 0, 4'b0000);
      apply(1, 1, 1, 0, 4'b0000);
      apply(1, 1, 1, 0, 4'b0000);
      apply(1, 0, 0, 1, 4'b0000);
      busy_cycles = 0;
      for (int k = 0; k < 20 && refund_busy; k++) begin
         busy_cycles++;
         apply(1, 0, 0, 0, 4'b0000);
         if (quarter_out) pulses.push_back(25);
         if (dime_out)    pulses.push_back(10);
         if (nickel_out)  pulses.push_back(5);
      end
      check("refund45 busy_cycles", 32'(busy_cycles), 32'd3);
      check("refund45 pulse_count", 32'(pulses.size()), 32'd3);
      seq = '{25, 10, 10};
      for (int k = 0; k < 3; k++)
         check($sformatf("refund45 pulse%0d", k),
               (k < pulses.size()) ? 32'(pulses[k]) : 32'hFFFF_FFFF, 32'(seq[k]));
      check("refund45 credit", 32'(credit), 32'd0);

      // Random stimulus against the reference model.
      apply(0, 0, 0, 0, 4'b0000);
      model_step(0, 0, 0, 0, 4'b0000);
      for (int k = 0; k < 3000; k++) begin
         bit       r, cv, cn;
         bit [1:0] ct;
         bit [3:0] vd;
         r  = ($urandom_range(0, 199) != 0);
         cv = ($urandom_range(0, 9) < 4);
         ct = 2'($urandom_range(0, 3));
         cn = ($urandom_range(0, 19) == 0);
         vd = 4'b0000;
         if ($urandom_range(0, 9) == 0) vd = 4'($urandom_range(1, 15));
         apply(r, cv, ct, cn, vd);
         model_step(r, cv, ct, cn, vd);
         check_all($sformatf("rnd%0d", k), m_credit, m_rj, m_q, m_d, m_n, m_refunding);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
